add_monitor: RTL and testbench

Self-checking result monitor for the registered `add` block; it is the consuming end of the adder's operand/result interface. Each enabled cycle it records the operands presented to the adder, predicts the sum, and compares it against the adder's output once the pipeline latency has elapsed. It keeps saturating match/mismatch counts, a sticky error flag, and a frozen capture of the first mismatch. It sits beside `add` instances in `top` and in benches, and is readable by the `$show_all_nets` VPI task.

---
 rtl/add_mon_pkg.sv | 19 +
 rtl/add_mon_dly.sv | 45 ++++
 rtl/add_monitor.sv | 116 +++++++++++
 tb/tb_add_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/add_mon_pkg.sv
// rtl/add_mon_pkg.sv - shared types, limits and helpers for the add result monitor
package add_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } mon_state_t;

  localparam int MAX_LATENCY = 4;

  // Increment that holds at the all-ones value of a counter `width` bits wide (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] limit;
    limit = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/add_mon_dly.sv
// rtl/add_mon_dly.sv - {valid, a, b, expected-sum} delay line; only the valid bits are reset
module add_mon_dly #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [DEPTH-1:0] valid,
  output logic [WIDTH-1:0] tail_a,
  output logic [WIDTH-1:0] tail_b,
  output logic [WIDTH-1:0] tail_exp
);

  logic [WIDTH-1:0] a_q   [DEPTH];
  logic [WIDTH-1:0] b_q   [DEPTH];
  logic [WIDTH-1:0] exp_q [DEPTH];

  // Truncating the concatenation keeps the form legal when DEPTH is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      valid <= DEPTH'({valid, en});
    end
  end

  always_ff @(posedge clk) begin
    a_q[0]   <= a;
    b_q[0]   <= b;
    exp_q[0] <= a + b;
    for (int i = 1; i < DEPTH; i++) begin
      a_q[i]   <= a_q[i-1];
      b_q[i]   <= b_q[i-1];
      exp_q[i] <= exp_q[i-1];
    end
  end

  assign tail_a   = a_q[DEPTH-1];
  assign tail_b   = b_q[DEPTH-1];
  assign tail_exp = exp_q[DEPTH-1];

endmodule

// File: rtl/add_monitor.sv
// rtl/add_monitor.sv - checks a registered adder's result against a delayed a+b prediction
module add_monitor
  import add_mon_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] out,
  input  logic             clear,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             error,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic             busy
);

  // Out-of-range latencies are clamped to the supported 1..MAX_LATENCY window.
  localparam int DEPTH = (LATENCY < 1) ? 1 : ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);

  mon_state_t       state;
  mon_state_t       state_next;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] remain;
  logic [WIDTH-1:0] tail_a;
  logic [WIDTH-1:0] tail_b;
  logic [WIDTH-1:0] tail_exp;
  logic             line_next;
  logic             compare;
  logic             hit;
  logic             miss;

  add_mon_dly #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a),
    .b       (b),
    .valid   (valid),
    .tail_a  (tail_a),
    .tail_b  (tail_b),
    .tail_exp(tail_exp)
  );

  // Entries still in the line after this edge: everything but the tail, plus a new sample.
  assign remain    = valid << 1;
  assign line_next = en | (|remain);

  assign compare = valid[DEPTH-1] & ~clear;
  assign hit     = compare & (out == tail_exp);
  assign miss    = compare & (out != tail_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN: begin
        if (miss)            state_next = FAULT;
        else if (!line_next) state_next = IDLE;
      end
      FAULT:   if (clear) state_next = line_next ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_a        <= '0;
      err_b        <= '0;
      err_exp      <= '0;
      err_got      <= '0;
    end else if (clear) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_a        <= '0;
      err_b        <= '0;
      err_exp      <= '0;
      err_got      <= '0;
    end else begin
      if (hit)  match_cnt    <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
      if (miss) mismatch_cnt <= CNT_W'(sat_inc(32'(mismatch_cnt), CNT_W));
      // Capture only the mismatch that takes us into FAULT; later ones just count.
      if (miss && state == RUN) begin
        err_a   <= tail_a;
        err_b   <= tail_b;
        err_exp <= tail_exp;
        err_got <= out;
      end
    end
  end

  assign error = (state == FAULT);
  assign busy  = |valid;

endmodule

// File: tb/tb_add_monitor.sv
// tb/tb_add_monitor.sv - directed bench for add_monitor at latency 1 and latency 3
module tb_add_monitor;
  import add_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        corrupt = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] sum1 = '0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [31:0] d3 = '0;

  logic [3:0]  m1_match, m1_mismatch;
  logic        m1_error, m1_busy;
  logic [31:0] m1_err_a, m1_err_b, m1_err_exp, m1_err_got;
  logic [15:0] m3_match, m3_mismatch;
  logic        m3_error, m3_busy;
  logic [31:0] m3_err_a, m3_err_b, m3_err_exp, m3_err_got;

  int checks = 0;
  int errors = 0;

  bit pat_en   [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
  int pat_cnt  [8] = '{0, 0, 0, 1, 1, 2, 3, 3};
  bit pat_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

  always #5 clk = ~clk;

  // Registered adder (corruptible) for m1, and a 3-deep adder pipeline for m3.
  always_ff @(posedge clk) sum1 <= corrupt ? 32'd0 : a + b;
  always_ff @(posedge clk) begin
    d1 <= a + b;
    d2 <= d1;
    d3 <= d2;
  end

  add_monitor #(.WIDTH(32), .LATENCY(1), .CNT_W(4)) m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .out(sum1), .clear(clear),
    .match_cnt(m1_match), .mismatch_cnt(m1_mismatch), .error(m1_error),
    .err_a(m1_err_a), .err_b(m1_err_b), .err_exp(m1_err_exp), .err_got(m1_err_got),
    .busy(m1_busy)
  );

  add_monitor #(.WIDTH(32), .LATENCY(3), .CNT_W(16)) m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .out(d3), .clear(clear),
    .match_cnt(m3_match), .mismatch_cnt(m3_mismatch), .error(m3_error),
    .err_a(m3_err_a), .err_b(m3_err_b), .err_exp(m3_err_exp), .err_got(m3_err_got),
    .busy(m3_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_match", m1_match, 0);
    check("rst_mismatch", m1_mismatch, 0);
    check("rst_error", m1_error, 0);
    check("rst_busy", m1_busy, 0);
    check("rst_state", m1.state, IDLE);
    rst_n = 1'b1;
    tick();

    // Clean run: a=5, b=0..9 back to back
    en = 1'b1; a = 32'd5; b = 32'd0;
    tick();
    check("clean_busy_rise", m1_busy, 1);
    check("clean_state_run", m1.state, RUN);
    for (int i = 1; i < 10; i++) begin
      b = 32'(i);
      tick();
    end
    en = 1'b0;
    tick();
    check("clean_match", m1_match, 10);
    check("clean_mismatch", m1_mismatch, 0);
    check("clean_error", m1_error, 0);
    check("clean_state_idle", m1.state, IDLE);
    check("clean_busy_fall", m1_busy, 0);

    // Injected fault on (5,3), then a second one on (5,4)
    en = 1'b1; a = 32'd5; b = 32'd3; corrupt = 1'b1;
    tick();
    b = 32'd4;
    tick();
    check("fault_error", m1_error, 1);
    check("fault_err_a", m1_err_a, 5);
    check("fault_err_b", m1_err_b, 3);
    check("fault_err_exp", m1_err_exp, 8);
    check("fault_err_got", m1_err_got, 0);
    check("fault_mismatch1", m1_mismatch, 1);
    en = 1'b0; corrupt = 1'b0;
    tick();
    check("fault_mismatch2", m1_mismatch, 2);
    check("fault_hold_b", m1_err_b, 3);
    check("fault_hold_exp", m1_err_exp, 8);
    check("fault_state", m1.state, FAULT);
    check("fault_match_kept", m1_match, 10);

    // Clear on the same edge as a mismatching compare
    en = 1'b1; a = 32'd5; b = 32'd1; corrupt = 1'b1;
    tick();
    en = 1'b0; corrupt = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_match", m1_match, 0);
    check("clr_mismatch", m1_mismatch, 0);
    check("clr_error", m1_error, 0);
    check("clr_err_a", m1_err_a, 0);
    check("clr_state", m1.state, IDLE);
    en = 1'b1; a = 32'd7; b = 32'd9; corrupt = 1'b1;
    tick();
    en = 1'b0; corrupt = 1'b0;
    tick();
    check("clr_next_error", m1_error, 1);
    check("clr_next_err_a", m1_err_a, 7);
    check("clr_next_err_b", m1_err_b, 9);
    check("clr_next_err_exp", m1_err_exp, 32'h10);
    check("clr_next_mismatch", m1_mismatch, 1);

    // Wrap-around: 0xFFFFFFFF + 2 = 1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b1; a = 32'hFFFF_FFFF; b = 32'd2;
    tick();
    en = 1'b0;
    tick();
    check("wrap_match", m1_match, 1);
    check("wrap_error", m1_error, 0);

    // Saturation: 20 more matches on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      en = 1'b1; a = 32'(i); b = 32'(i * 2);
      tick();
    end
    en = 1'b0;
    tick();
    check("sat_match", m1_match, 15);
    check("sat_mismatch", m1_mismatch, 0);

    // Gapped enable 1,0,1,1,0 against the latency-3 monitor
    for (int i = 0; i < 4; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("gap_start_match", m3_match, 0);
    check("gap_start_busy", m3_busy, 0);
    for (int i = 0; i < 8; i++) begin
      en = pat_en[i]; a = 32'(i * 3); b = 32'd100;
      tick();
      check($sformatf("gap_cnt%0d", i), m3_match, pat_cnt[i]);
      check($sformatf("gap_busy%0d", i), m3_busy, pat_busy[i]);
    end
    check("gap_mismatch", m3_mismatch, 0);
    check("gap_state", m3.state, IDLE);

    // Asynchronous reset with transactions in flight
    clear = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b1; a = 32'd1; b = 32'd1; corrupt = 1'b1;
    tick();
    a = 32'd2; b = 32'd2; corrupt = 1'b0;
    tick();
    check("pre_rst_error", m1_error, 1);
    check("pre_rst_m3_busy", m3_busy, 1);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("arst_error", m1_error, 0);
    check("arst_err_a", m1_err_a, 0);
    check("arst_err_got", m1_err_got, 0);
    check("arst_err_exp", m1_err_exp, 0);
    check("arst_mismatch", m1_mismatch, 0);
    check("arst_busy", m1_busy, 0);
    check("arst_m3_busy", m3_busy, 0);
    check("arst_m3_state", m3.state, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_m1_match", m1_match, 0);
    check("post_rst_m1_mismatch", m1_mismatch, 0);
    check("post_rst_m3_match", m3_match, 0);
    check("post_rst_m3_mismatch", m3_mismatch, 0);
    check("post_rst_m3_error", m3_error, 0);
    check("post_rst_m3_err_a", m3_err_a, 0);
    check("post_rst_m3_err_b", m3_err_b, 0);
    check("post_rst_m3_err_exp", m3_err_exp, 0);
    check("post_rst_m3_err_got", m3_err_got, 0);
    check("post_rst_m1_err_b", m1_err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
